lsu_dm_master: RTL and testbench
================================

Name: lsu_dm_master

Overview:
- Load/store initiator that sits between the CPU MEM stage and the word-organised 4 KiB data memory.
- Accepts one byte, halfword or word load/store request at a time on a valid/ready handshake.
- Drives the memory's word address, write data, write-enable and read-enable.
- Byte and halfword stores are performed as read-modify-write; loads are returned lane-extracted and sign- or zero-extended.

Parameters:
AW, 10, word-index width of the data memory (word address = addr[AW+1:2])
MISALIGN_ERR, 1, 1: misaligned LW/SW/LH/LHU/SH return rsp_err and make no memory access; 0: low address bits are forced to alignment and the access proceeds

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready at the clock edge
req_op  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
req_addr  input  32  byte address; bits above AW+1 ignored (wrap)
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present; held until rsp_ready
rsp_ready  input  1  response consumed
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned access (MISALIGN_ERR=1 only)
dm_addr  output  AW  word address to memory
dm_din  output  32  write data to memory
dm_wr  output  1  memory write enable, sampled at clock edge
dm_rd  output  1  memory read enable; dm_dout valid the cycle after the sampling edge
dm_dout  input  32  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; all other outputs 0, including dm_rd, dm_wr, dm_addr, dm_din, rsp_rdata and rsp_err; latched request cleared.
- States: IDLE, RD, CAP, WR, RSP. dm_rd and dm_wr are Moore decodes of the state: dm_rd=1 only in RD; dm_wr=1 only in WR.
- IDLE:
  - req_ready=1.
  - On acceptance, latch op, address and wdata.
  - Misaligned with MISALIGN_ERR=1 -> RSP with rsp_err=1.
  - SW -> WR.
  - All loads, SB and SH -> RD.
- RD: drive dm_addr from the latched address; -> CAP.
- CAP (dm_dout valid):
  - Load: select the lane by addr[1:0] (byte) or addr[1] (half), extend (LB/LH sign, LBU/LHU zero), register into rsp_rdata; -> RSP.
  - SB/SH: merge req_wdata[7:0] or [15:0] into the dm_dout lane and register the result as dm_din; -> WR.
- WR: dm_din = wdata (SW) or merged word; memory commits at the exiting edge; -> RSP.
- RSP: rsp_valid=1 with rsp_rdata and rsp_err stable; on rsp_ready -> IDLE. No new request is accepted in the same cycle.
- Latency, acceptance edge to rsp_valid:
  - Load: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Error: 1 cycle.
- Lane order is little-endian: addr[1:0]=0 is bits [7:0].
- Memory read returns pre-write data. Requests are non-overlapping, so RMW never sees its own write.
- Reset mid-operation: outputs drop immediately. An RMW aborted before its WR edge leaves memory unchanged, and no response is produced.
- rsp_ready held high in RSP: returns to IDLE next cycle. req_valid may stay high throughout; it is ignored outside IDLE.

Decomposition:
- lsu_defs.vh: op encodings, state encodings, lane-select constants.
- One combinational sub-module, lsu_lane: load extraction/extension and store merge, shared by the CAP logic.
- FSM, request latch and handshake stay in lsu_dm_master.

Test Plan:
- Reset then SW addr 0x00000008 wdata 0xDEADBEEF -> dm_wr=1 one cycle with dm_addr=2, dm_din=0xDEADBEEF; rsp_valid 2 cycles after acceptance, rsp_err=0.
- With word 2 = 0xDEADBEEF: LB addr 0x0B -> rsp_rdata 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x08 -> 0xFFFFBEEF; LHU 0x0A -> 0x0000DEAD; each 3 cycles latency.
- SB addr 0x09 wdata 0x55 over 0xDEADBEEF -> dm_rd then dm_wr with dm_din=0xDEAD55EF; SH addr 0x0A wdata 0x1234 -> 0x123455EF.
- LW addr 0x06 with MISALIGN_ERR=1 -> rsp_err=1 one cycle after acceptance, dm_rd/dm_wr never asserted; same with MISALIGN_ERR=0 -> reads word 1.
- Back-pressure: rsp_ready=0 for 5 cycles in RSP -> rsp_valid and rsp_rdata stable, req_ready=0; then the next request is accepted only after return to IDLE.
- rst_n pulsed low during CAP of SB -> dm_wr never asserted, memory word unchanged, no response; next LW returns the original value.

Source files
------------

// File: rtl/lsu_dm_master_pkg.sv
// Shared definitions for the load/store initiator: op and state encodings,
// access-size decode and alignment helpers.
package lsu_dm_master_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_B;
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            default:              return SIZE_W;
        endcase
    endfunction

    function automatic logic is_load(input op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic misaligned(input op_e op, input logic [1:0] lo);
        case (op_size(op))
            SIZE_H:  return lo[0];
            SIZE_W:  return |lo;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the low address bits that the access size makes meaningless.
    function automatic logic [1:0] align_lo(input op_e op, input logic [1:0] lo);
        case (op_size(op))
            SIZE_H:  return {lo[1], 1'b0};
            SIZE_W:  return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dm_master_lane.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges byte/halfword store data into the word read for read-modify-write.
module lsu_dm_master_lane
    import lsu_dm_master_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] store,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: LANE_W];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_data = '0;
        merged    = word;
        case (op)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LW:  load_data = word;
            OP_SB:  merged[{lane, 3'b000} +: LANE_W] = store[7:0];
            OP_SH: begin
                if (lane[1]) merged[31:16] = store;
                else         merged[15:0]  = store;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_dm_master.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Sub-word stores are read-modify-write; loads return extended lane data.
module lsu_dm_master
    import lsu_dm_master_pkg::*;
#(
    parameter int AW           = 10,
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_wr,
    output logic          dm_rd,
    input  logic [31:0]   dm_dout
);

    state_e        state, state_next;
    op_e           op_in, op_q;
    logic [AW+1:0] addr_q;
    logic [15:0]   wdata_q;
    logic          accept, err_in;
    logic [31:0]   load_data, merged;
    logic          unused_addr_hi;

    assign op_in          = op_e'(req_op);
    assign accept         = (state == ST_IDLE) && req_valid;
    assign err_in         = MISALIGN_ERR && misaligned(op_in, req_addr[1:0]);
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RSP);
    assign dm_rd     = (state == ST_RD);
    assign dm_wr     = (state == ST_WR);
    assign dm_addr   = addr_q[AW+1:2];

    lsu_dm_master_lane u_lane (
        .op        (op_q),
        .lane      (addr_q[1:0]),
        .word      (dm_dout),
        .store     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (err_in)               state_next = ST_RSP;
                    else if (op_in == OP_SW)  state_next = ST_WR;
                    else                      state_next = ST_RD;
                end
            end
            ST_RD:   state_next = ST_CAP;
            ST_CAP:  state_next = is_load(op_q) ? ST_RSP : ST_WR;
            ST_WR:   state_next = ST_RSP;
            ST_RSP:  if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Response is cleared at acceptance so stores and errors return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LB;
            addr_q    <= '0;
            wdata_q   <= '0;
            dm_din    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= op_in;
                addr_q    <= {req_addr[AW+1:2], align_lo(op_in, req_addr[1:0])};
                wdata_q   <= req_wdata[15:0];
                rsp_rdata <= '0;
                rsp_err   <= err_in;
                if (op_in == OP_SW) dm_din <= req_wdata;
            end
            if (state == ST_CAP) begin
                if (is_load(op_q)) rsp_rdata <= load_data;
                else               dm_din    <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dm_master.sv
// Self-checking bench for lsu_dm_master: directed vector table, hand-written
// corner sequences and randomized traffic against a word-array reference model.
module tb_lsu_dm_master;

    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Instance under test with misalignment errors enabled.
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, dm_wr, dm_rd;
    logic [2:0]    req_op;
    logic [31:0]   req_addr, req_wdata, rsp_rdata, dm_din, dm_dout;
    logic [AW-1:0] dm_addr;

    lsu_dm_master #(.AW(AW), .MISALIGN_ERR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_dout(dm_dout)
    );

    // Second instance with forced alignment.
    logic          req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b, dm_wr_b, dm_rd_b;
    logic [2:0]    req_op_b;
    logic [31:0]   req_addr_b, req_wdata_b, rsp_rdata_b, dm_din_b, dm_dout_b;
    logic [AW-1:0] dm_addr_b;

    lsu_dm_master #(.AW(AW), .MISALIGN_ERR(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .dm_addr(dm_addr_b), .dm_din(dm_din_b), .dm_wr(dm_wr_b), .dm_rd(dm_rd_b), .dm_dout(dm_dout_b)
    );

    // Data memory models: a real array for the main instance, an address pattern for the second.
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (dm_rd) dm_dout <= mem[dm_addr];
        if (dm_wr) mem[dm_addr] <= dm_din;
    end
    always @(posedge clk) begin
        if (dm_rd_b) dm_dout_b <= 32'hA5A5_0000 | {22'h0, dm_addr_b};
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else             n_pass++;
    endtask

    // Reference model: memory as a plain word array, rules as arithmetic.
    logic [31:0] ref_mem [NW];

    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd,
                                  output logic er, output int lat);
        int          idx, bytes, sh8, sh16;
        logic [31:0] w, b, h;
        idx   = int'((addr >> 2) % NW);
        sh8   = int'(addr % 4) * 8;
        sh16  = int'((addr / 2) % 2) * 16;
        w     = ref_mem[idx];
        bytes = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
        rd = 0; er = 0;
        if (addr % bytes != 0) begin
            er = 1; lat = 1;
            return;
        end
        b = (w >> sh8) & 32'hFF;
        h = (w >> sh16) & 32'hFFFF;
        lat = (op <= 4) ? 3 : (op == 7) ? 2 : 4;
        case (op)
            0: rd = (b >= 128) ? b - 32'd256 : b;
            1: rd = b;
            2: rd = (h >= 32768) ? h - 32'd65536 : h;
            3: rd = h;
            4: rd = w;
            5: ref_mem[idx] = (w & ~(32'hFF << sh8)) | ((wdata & 32'hFF) << sh8);
            6: ref_mem[idx] = (w & ~(32'hFFFF << sh16)) | ((wdata & 32'hFFFF) << sh16);
            default: ref_mem[idx] = wdata;
        endcase
    endfunction

    // One complete transaction on the main instance; latency counts from the acceptance edge.
    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, output logic [31:0] rdata, output logic err,
                           output int lat, output int rd_cnt, output int wr_cnt,
                           output logic [31:0] wr_din, output logic [31:0] wr_addr);
        int n;
        rd_cnt = 0; wr_cnt = 0; wr_din = 0; wr_addr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            if (dm_rd) rd_cnt++;
            if (dm_wr) begin wr_cnt++; wr_din = dm_din; wr_addr = 32'(dm_addr); end
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata; err = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_b(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [31:0] rd_addr, output logic [31:0] wr_din);
        rd_addr = 32'hFFFF_FFFF; wr_din = 0;
        @(negedge clk);
        req_valid_b = 1'b1; req_op_b = op; req_addr_b = addr; req_wdata_b = wdata;
        @(negedge clk);
        req_valid_b = 1'b0;
        lat = 1;
        while (!rsp_valid_b && lat < 16) begin
            if (dm_rd_b) rd_addr = 32'(dm_addr_b);
            if (dm_wr_b) wr_din = dm_din_b;
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata_b; err = rsp_err_b;
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_b = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_din;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] rdata, wr_din, wr_addr, mdl_rd, exp_a, exp_b, orig;
    logic        err, mdl_er;
    int          lat, rd_cnt, wr_cnt, mdl_lat, n, wr_during, bad, rsp_during;

    initial begin
        vecs[0]  = '{3'd7, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 32'hDEAD_BEEF};
        vecs[1]  = '{3'd0, 32'h0000_000B, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 32'h0};
        vecs[2]  = '{3'd1, 32'h0000_000B, 32'h0,         32'h0000_00DE, 1'b0, 3, 32'h0};
        vecs[3]  = '{3'd2, 32'h0000_0008, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 32'h0};
        vecs[4]  = '{3'd3, 32'h0000_000A, 32'h0,         32'h0000_DEAD, 1'b0, 3, 32'h0};
        vecs[5]  = '{3'd5, 32'h0000_0009, 32'h0000_0055, 32'h0000_0000, 1'b0, 4, 32'hDEAD_55EF};
        vecs[6]  = '{3'd6, 32'h0000_000A, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 4, 32'h1234_55EF};
        vecs[7]  = '{3'd4, 32'h0000_0008, 32'h0,         32'h1234_55EF, 1'b0, 3, 32'h0};
        vecs[8]  = '{3'd4, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1, 1, 32'h0};
        vecs[9]  = '{3'd6, 32'h0000_0005, 32'h0000_7777, 32'h0000_0000, 1'b1, 1, 32'h0};
        vecs[10] = '{3'd0, 32'h8000_100B, 32'h0,         32'h0000_0012, 1'b0, 3, 32'h0};
        vecs[11] = '{3'd2, 32'h0000_0003, 32'h0,         32'h0000_0000, 1'b1, 1, 32'h0};
        vecs[12] = '{3'd1, 32'h0000_000A, 32'h0,         32'h0000_0034, 1'b0, 3, 32'h0};

        for (int i = 0; i < NW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        req_valid_b = 0; req_op_b = 0; req_addr_b = 0; req_wdata_b = 0; rsp_ready_b = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dm_rd",     32'(dm_rd),     32'd0);
        check("rst_dm_wr",     32'(dm_wr),     32'd0);
        check("rst_dm_addr",   32'(dm_addr),   32'd0);
        check("rst_dm_din",    dm_din,         32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, mdl_rd, mdl_er, mdl_lat);
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, 0, rdata, err, lat,
                    rd_cnt, wr_cnt, wr_din, wr_addr);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rd_cnt", i), 32'(rd_cnt),
                  (vecs[i].exp_err || vecs[i].op == 3'd7) ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_wr_cnt", i), 32'(wr_cnt),
                  (!vecs[i].exp_err && vecs[i].op >= 3'd5) ? 32'd1 : 32'd0);
            if (!vecs[i].exp_err && vecs[i].op >= 3'd5) begin
                check($sformatf("vec%0d_wr_din", i), wr_din, vecs[i].exp_din);
                check($sformatf("vec%0d_wr_addr", i), wr_addr, (vecs[i].addr >> 2) % NW);
            end
        end

        // Forced-alignment instance: LW 0x06 reads word 1; SH 0x0B merges into the upper half of word 2.
        run_b(3'd4, 32'h0000_0006, 32'h0, rdata, err, lat, wr_addr, wr_din);
        check("noerr_lw_rdata", rdata, 32'hA5A5_0001);
        check("noerr_lw_err",   32'(err), 32'd0);
        check("noerr_lw_lat",   32'(lat), 32'd3);
        check("noerr_lw_addr",  wr_addr, 32'd1);
        run_b(3'd6, 32'h0000_000B, 32'h0000_BEEF, rdata, err, lat, wr_addr, wr_din);
        check("noerr_sh_din",   wr_din, 32'hBEEF_0002);
        check("noerr_sh_lat",   32'(lat), 32'd4);

        // Back-pressure with a second request waiting on req_valid throughout.
        model(3'd4, 32'h0000_0008, 32'h0, exp_a, mdl_er, mdl_lat);
        model(3'd1, 32'h0000_0009, 32'h0, exp_b, mdl_er, mdl_lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_0008;
        @(negedge clk);
        req_op = 3'd1; req_addr = 32'h0000_0009;
        n = 0;
        while (!rsp_valid && n < 16) begin @(negedge clk); n++; end
        check("bp_first_rdata", rsp_rdata, exp_a);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_hold%0d_rdata", k), rsp_rdata, exp_a);
            check($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_req_ready", 32'(req_ready), 32'd1);
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 16) begin @(negedge clk); n++; end
        check("bp_second_rdata", rsp_rdata, exp_b);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulsed during CAP of an SB: no write, no response, memory intact.
        orig = ref_mem[3];
        wr_during = 0; rsp_during = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h0000_000D; req_wdata = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        if (dm_wr) wr_during++;
        @(negedge clk);
        if (dm_wr) wr_during++;
        rst_n = 1'b0;
        #1;
        check("abort_dm_wr",     32'(dm_wr),     32'd0);
        check("abort_dm_rd",     32'(dm_rd),     32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_dm_din",    dm_din,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dm_wr) wr_during++;
            if (rsp_valid) rsp_during++;
        end
        check("abort_wr_seen",  32'(wr_during),  32'd0);
        check("abort_rsp_seen", 32'(rsp_during), 32'd0);
        check("abort_mem_word", mem[3], orig);
        run_req(3'd4, 32'h0000_000C, 32'h0, 0, rdata, err, lat, rd_cnt, wr_cnt, wr_din, wr_addr);
        check("abort_lw_rdata", rdata, orig);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] addr, wd;
            op   = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wd   = $urandom;
            model(op, addr, wd, mdl_rd, mdl_er, mdl_lat);
            run_req(op, addr, wd, $urandom_range(0, 2), rdata, err, lat, rd_cnt, wr_cnt, wr_din, wr_addr);
            check($sformatf("rnd%0d_op%0d_rdata", i, op), rdata, mdl_rd);
            check($sformatf("rnd%0d_op%0d_err", i, op), 32'(err), 32'(mdl_er));
            check($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), 32'(mdl_lat));
        end

        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_differing", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
